mem_agu_queue: RTL

Parametrised front end of the memory unit: replaces the single intake register with a DEPTH-entry queue that has valid/ready backpressure toward the operand collector. Per-lane effective addresses are computed and range-checked on enqueue. Selected warps can be flushed, and entries are presented in order to the cache/MSHR stage. Lane count, data width and address space are generic, so one design serves 8-, 16- and 32-lane configurations.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_agu_lane.sv | 35 +++
 rtl/mem_agu_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory-unit front end.
//   op_t      : decoded operation type (read / write / shared-space select)
//   SCB_W     : scoreboard tag width
//   REG_W     : destination register tag width
//   decode_op : folds the illegal read+write combination onto read
// The per-entry record depends on lane count and widths, so it is declared
// inside mem_agu_queue from that module's parameters.
package mem_pkg;
  localparam int SCB_W = 2;
  localparam int REG_W = 5;

  typedef struct packed {
    logic rd;
    logic wr;
    logic sh;
  } op_t;

  function automatic op_t decode_op(input logic r, input logic w, input logic s);
    op_t o;
    o.rd = r;
    o.wr = w & ~r;
    o.sh = s;
    return o;
  endfunction
endpackage

// File: rtl/mem_agu_lane.sv
// mem_agu_lane: effective address and range check for one lane.
// Ports:
//   rs       in  base register value (zero-extended)
//   offset   in  signed 8-bit immediate
//   shared   in  1 = shared space (limit SHMEM_SIZE, based at MEM_SIZE)
//   active   in  lane is in the active-thread mask
//   eff_addr out unified address (0 for inactive lanes)
//   ok       out active and in range
//   oob      out active and out of range
module mem_agu_lane #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int MEM_SIZE   = 256,
  parameter int SHMEM_SIZE = 256
) (
  input  logic [DATA_W-1:0] rs,
  input  logic [7:0]        offset,
  input  logic              shared,
  input  logic              active,
  output logic [ADDR_W-1:0] eff_addr,
  output logic              ok,
  output logic              oob
);
  logic [DATA_W:0] sum, lim;
  logic            ovf;

  assign sum = {1'b0, rs} + {{(DATA_W-7){offset[7]}}, offset};
  assign lim = shared ? (DATA_W+1)'(SHMEM_SIZE) : (DATA_W+1)'(MEM_SIZE);
  // Top bit set means the sum went negative (or wrapped past DATA_W bits).
  assign ovf = sum[DATA_W] | (sum >= lim);

  assign eff_addr = active ? (sum[ADDR_W-1:0] + (shared ? ADDR_W'(MEM_SIZE) : '0)) : '0;
  assign ok       = active & ~ovf;
  assign oob      = active & ovf;
endmodule

// File: rtl/mem_agu_queue.sv
// mem_agu_queue: DEPTH-entry in-order queue in front of the cache/MSHR stage.
// Addresses are computed and range-checked on enqueue; entries of a warp can
// be killed by flush and are then dropped silently at the head.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready, in_read/in_write/in_shared, in_pam, in_warp/in_scb/in_reg,
//   in_rs, in_rt, in_offset        : intake
//   flush_valid, flush_warp        : kill queued entries of a warp
//   out_valid/out_ready, out_*     : head entry toward the cache stage
//   occupancy                      : entries held (including killed ones)
// Optional feature: MEM_COALESCE_EN adds per-entry same-line detection
// (out_same_line / out_line_addr); without it both are tied to 0.
module mem_agu_queue
  import mem_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int NUM_WARPS  = 8,
  parameter int WARP_W     = $clog2(NUM_WARPS),
  parameter int MEM_SIZE   = 256,
  parameter int SHMEM_SIZE = 256,
  parameter int ADDR_W     = $clog2(MEM_SIZE + SHMEM_SIZE),
  parameter int LINE_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_read,
  input  logic                          in_write,
  input  logic                          in_shared,
  input  logic [NUM_LANES-1:0]          in_pam,
  input  logic [WARP_W-1:0]             in_warp,
  input  logic [SCB_W-1:0]              in_scb,
  input  logic [REG_W-1:0]              in_reg,
  input  logic [NUM_LANES*DATA_W-1:0]   in_rs,
  input  logic [NUM_LANES*DATA_W-1:0]   in_rt,
  input  logic [7:0]                    in_offset,
  input  logic                          flush_valid,
  input  logic [WARP_W-1:0]             flush_warp,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_read,
  output logic                          out_write,
  output logic                          out_shared,
  output logic [NUM_LANES-1:0]          out_pam,
  output logic [NUM_LANES-1:0]          out_oob_mask,
  output logic [WARP_W-1:0]             out_warp,
  output logic [SCB_W-1:0]              out_scb,
  output logic [REG_W-1:0]              out_reg,
  output logic [NUM_LANES*ADDR_W-1:0]   out_eff_addr,
  output logic [NUM_LANES*DATA_W-1:0]   out_wdata,
  output logic                          out_same_line,
  output logic [ADDR_W-LINE_SHIFT-1:0]  out_line_addr,
  output logic [$clog2(DEPTH):0]        occupancy
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LINE_W = ADDR_W - LINE_SHIFT;

  typedef struct packed {
    op_t                                op;
    logic [WARP_W-1:0]                  warp;
    logic [SCB_W-1:0]                   scb;
    logic [REG_W-1:0]                   rg;
    logic [NUM_LANES-1:0]               pam;
    logic [NUM_LANES-1:0]               oob;
    logic [NUM_LANES-1:0][ADDR_W-1:0]   addr;
    logic [NUM_LANES-1:0][DATA_W-1:0]   wdata;
`ifdef MEM_COALESCE_EN
    logic                               same;
    logic [LINE_W-1:0]                  line;
`endif
  } entry_t;

  op_t                              op;
  logic [NUM_LANES-1:0][DATA_W-1:0] rs_a;
  logic [NUM_LANES-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_LANES-1:0]             ok_a, oob_a;
  entry_t                           new_e, out_q;
  entry_t                           mem [DEPTH];
  logic [DEPTH-1:0]                 kill;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr, nxt_rd;
  logic [CNT_W-1:0]                 count, cnt_left;
  logic                             acc, push, pop, head;

  assign op   = decode_op(in_read, in_write, in_shared);
  assign rs_a = in_rs;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mem_agu_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_SIZE(MEM_SIZE), .SHMEM_SIZE(SHMEM_SIZE)
    ) u_lane (
      .rs(rs_a[g]), .offset(in_offset), .shared(op.sh), .active(in_pam[g]),
      .eff_addr(addr_a[g]), .ok(ok_a[g]), .oob(oob_a[g])
    );
  end

`ifdef MEM_COALESCE_EN
  // Reference line is taken from the first in-range lane; every other
  // in-range lane must match it.
  logic [LINE_W-1:0] ln_ref;
  logic              ln_found, ln_same;
  always_comb begin
    ln_ref   = '0;
    ln_found = 1'b0;
    ln_same  = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (ok_a[i]) begin
        if (!ln_found) begin
          ln_ref   = addr_a[i][ADDR_W-1:LINE_SHIFT];
          ln_found = 1'b1;
        end else if (addr_a[i][ADDR_W-1:LINE_SHIFT] != ln_ref) begin
          ln_same = 1'b0;
        end
      end
    end
  end
`endif

  always_comb begin
    new_e       = '0;
    new_e.op    = op;
    new_e.warp  = in_warp;
    new_e.scb   = in_scb;
    new_e.rg    = in_reg;
    new_e.pam   = ok_a;
    new_e.oob   = oob_a;
    new_e.addr  = addr_a;
    new_e.wdata = in_rt;
`ifdef MEM_COALESCE_EN
    new_e.same  = ln_same;
    new_e.line  = ln_ref;
`endif
  end

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign acc       = in_valid & in_ready;
  // No-op ops and ops of a warp being flushed this cycle are swallowed.
  assign push      = acc & (op.rd | op.wr) & ~(flush_valid & (flush_warp == in_warp));
  assign head      = (count != '0);
  assign out_valid = head & ~kill[rd_ptr];
  assign pop       = head & (kill[rd_ptr] | out_ready);
  assign nxt_rd    = rd_ptr + PTR_W'(pop);
  assign cnt_left  = count - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_e;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      kill   <= '0;
      out_q  <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= nxt_rd;
      // Stale slots may pick up a kill bit; a push always clears its slot.
      for (int i = 0; i < DEPTH; i++)
        if (flush_valid && mem[i].warp == flush_warp) kill[i] <= 1'b1;
      if (push) kill[wr_ptr] <= 1'b0;
      // Output register tracks the next head; with nothing left it takes the
      // incoming entry, otherwise it holds its last value.
      if (cnt_left != '0) out_q <= mem[nxt_rd];
      else if (push)      out_q <= new_e;
    end
  end

  assign out_read     = out_q.op.rd;
  assign out_write    = out_q.op.wr;
  assign out_shared   = out_q.op.sh;
  assign out_pam      = out_q.pam;
  assign out_oob_mask = out_q.oob;
  assign out_warp     = out_q.warp;
  assign out_scb      = out_q.scb;
  assign out_reg      = out_q.rg;
  assign out_eff_addr = out_q.addr;
  assign out_wdata    = out_q.wdata;
  assign occupancy    = count;
`ifdef MEM_COALESCE_EN
  assign out_same_line = out_q.same;
  assign out_line_addr = out_q.line;
`else
  assign out_same_line = 1'b0;
  assign out_line_addr = '0;
`endif
endmodule
